song_control: RTL
=================

// Module: song_control
// PURPOSE
// - Playback sequencer for the song elapsed-time counter; sits between the central FSM buttons and the timer.
// - Runs a count-in before each song and starts the timer with a start_song pulse.
// - Holds pause_song high whenever the song is not actively playing.
// - Ends a song on song_done (from memory) or on the length cap; aborts a pause that exceeds its timeout.
// PARAMETERS
// - TICK_DIV       27000000  clk cycles per 1 s tick (27 MHz system clock)
// - COUNT_IN       3         count-in length, seconds (1..3)
// - PAUSE_TIMEOUT  30        seconds in PAUSED before automatic return to IDLE (1..255)
// - MAX_SECONDS    240       timer value at which PLAY is forced to DONE (1..255)
// PORTS
// - clk          in   1  system clock
// - reset        in   1  synchronous, active-high
// - play         in   1  1-cycle pulse: request song start
// - pause        in   1  1-cycle pulse: toggle pause
// - stop         in   1  1-cycle pulse: abort to IDLE
// - song_done    in   1  level from song memory: end of data reached
// - seconds      in   8  elapsed seconds from the timer
// - start_song   out  1  1-cycle pulse to timer: clear and run
// - pause_song   out  1  level to timer: hold count
// - playing      out  1  high in PLAY
// - finished     out  1  1-cycle pulse on entry to DONE
// - countdown    out  2  remaining count-in seconds; 0 outside COUNTIN
// - state        out  3  current state, for graphics/display
// BEHAVIOUR
// - States: IDLE=0, COUNTIN=1, PLAY=2, PAUSED=3, DONE=4; codes 5-7 decode to IDLE next cycle.
// - All outputs registered; transition takes effect on the edge after the input is sampled.
// - Reset (overrides all): state=IDLE, start_song=0, pause_song=1, playing=0, finished=0, countdown=0, tick counter=0.
// - pause_song = 1 in every state except PLAY; playing = (state==PLAY).
// - Tick counter: 0..TICK_DIV-1; tick when count==TICK_DIV-1; cleared on every state change.
// - IDLE:
//   - play -> COUNTIN, countdown<=COUNT_IN.
//   - pause/stop ignored.
// - COUNTIN:
//   - stop -> IDLE.
//   - else on tick countdown<=countdown-1.
//   - on tick with countdown==1 -> PLAY, start_song<=1 for exactly one cycle, countdown<=0.
//   - play/pause ignored.
// - PLAY, priority stop > end > pause:
//   - stop -> IDLE.
//   - song_done | seconds>=MAX_SECONDS -> DONE, finished<=1 for one cycle.
//   - pause -> PAUSED.
//   - play ignored.
// - PAUSED, priority stop > pause > timeout:
//   - stop -> IDLE.
//   - pause -> PLAY; no start_song, timer resumes.
//   - 8-bit pause-seconds count increments on tick, cleared on entry; reaching PAUSE_TIMEOUT -> IDLE.
//   - song_done ignored.
// - DONE:
//   - play -> COUNTIN; stop -> IDLE; pause ignored.
//   - Held until play or stop even if song_done drops.
// - Same-cycle play+stop in any state: stop wins.
// STRUCTURE
// - song_control_defs.vh: state localparams and COUNTIN/ tick width constants.
// - Sub-module one_sec_tick (clk, reset, clear, tick; param TICK_DIV): 25-bit divider with synchronous clear.
// - song_control instantiates one_sec_tick, the 3-bit state register, the 2-bit countdown and the 8-bit pause counter.
// TESTING (TICK_DIV=4, COUNT_IN=3, PAUSE_TIMEOUT=2, MAX_SECONDS=10)
// - Count-in: reset, play pulse at edge 0.
//   - -> state=1 from edge 1; countdown 3,2,1.
//   - -> state=2 and start_song=1 for one cycle after edge 13; pause_song falls the same cycle.
// - Pause/resume: in PLAY, pause pulse.
//   - -> state=3, pause_song=1.
//   - Second pause before 8 cycles -> state=2, start_song stays 0.
// - Pause timeout: in PAUSED, no input for 2*4 cycles -> state=0, pause_song=1.
// - End of song:
//   - In PLAY, drive song_done=1 -> state=4, finished pulse 1 cycle.
//   - Separately, seconds=10 -> DONE.
//   - Then play -> COUNTIN.
// - Priority: in PLAY, assert stop+song_done+pause together -> state=0, finished=0.
// - Reset mid-count-in: reset at countdown=2 -> all outputs at reset values next cycle; later play restarts at countdown=3.

Source files
------------

// File: rtl/song_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : song_control_pkg
//  Description : Shared state encoding and field widths for the song
//                playback sequencer and its one-second tick divider.
//  Revision    : 1.0  initial release
// ============================================================================
package song_control_pkg;

    // Encoding is visible on the state output, so values are pinned.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COUNTIN = 3'd1,
        S_PLAY    = 3'd2,
        S_PAUSED  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam int c_TICK_W = 25;   // holds 27_000_000 - 1
    localparam int c_CD_W   = 2;    // count-in seconds, 1..3
    localparam int c_PCNT_W = 8;    // pause seconds, up to 255

endpackage : song_control_pkg
`default_nettype wire

// File: rtl/one_sec_tick.sv
`default_nettype none
// ============================================================================
//  Module      : one_sec_tick
//  Description : Free-running clock divider producing a one-cycle tick every
//                TICK_DIV cycles. A synchronous clear restarts the period so
//                the owner can align seconds to its own state changes.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk    in  1  system clock
//    reset  in  1  synchronous, active-high
//    clear  in  1  restart the period (count returns to 0 next edge)
//    tick   out 1  high while the count sits at TICK_DIV-1
// ============================================================================
module one_sec_tick
    import song_control_pkg::*;
#(
    parameter int unsigned TICK_DIV = 27000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [c_TICK_W-1:0] c_LAST = c_TICK_W'(TICK_DIV - 1);

    logic [c_TICK_W-1:0] r_cnt;

    assign tick = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_TICK_W'(1);
        end
    end

endmodule : one_sec_tick
`default_nettype wire

// File: rtl/song_control.sv
`default_nettype none
// ============================================================================
//  Module      : song_control
//  Description : Playback sequencer between the front-panel FSM and the song
//                elapsed-time counter. Runs a count-in, starts the timer,
//                holds it while not playing, ends the song on song_done or
//                the length cap, and abandons an over-long pause.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk         in  1  system clock
//    reset       in  1  synchronous, active-high
//    play        in  1  pulse: start a song
//    pause       in  1  pulse: toggle pause
//    stop        in  1  pulse: abort to IDLE
//    song_done   in  1  level: song memory exhausted
//    seconds     in  8  elapsed seconds from the timer
//    start_song  out 1  pulse: clear and run the timer
//    pause_song  out 1  level: hold the timer
//    playing     out 1  high in PLAY
//    finished    out 1  pulse on entry to DONE
//    countdown   out 2  remaining count-in seconds, 0 elsewhere
//    state       out 3  current state code
// ============================================================================
module song_control
    import song_control_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 27000000,
    parameter int unsigned COUNT_IN      = 3,
    parameter int unsigned PAUSE_TIMEOUT = 30,
    parameter int unsigned MAX_SECONDS   = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play,
    input  logic       pause,
    input  logic       stop,
    input  logic       song_done,
    input  logic [7:0] seconds,
    output logic       start_song,
    output logic       pause_song,
    output logic       playing,
    output logic       finished,
    output logic [1:0] countdown,
    output logic [2:0] state
);

    localparam logic [c_CD_W-1:0]   c_COUNT_IN = c_CD_W'(COUNT_IN);
    localparam logic [c_PCNT_W-1:0] c_PAUSE_TO = c_PCNT_W'(PAUSE_TIMEOUT);
    localparam logic [7:0]          c_MAX_SEC  = 8'(MAX_SECONDS);

    state_t               r_state,     w_state_nx;
    logic [c_CD_W-1:0]    r_countdown, w_countdown_nx;
    logic [c_PCNT_W-1:0]  r_pause_cnt, w_pause_cnt_nx;
    logic                 r_start,     w_start_nx;
    logic                 r_finished,  w_finished_nx;
    logic                 r_pause_song;
    logic                 r_playing;

    logic                 w_tick;
    logic                 w_state_change;
    logic                 w_song_end;
    logic [c_PCNT_W-1:0]  w_pause_inc;

    // Restarting the divider on every state change makes each state's first
    // second a full TICK_DIV cycles long.
    assign w_state_change = (w_state_nx != r_state);

    one_sec_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (w_state_change),
        .tick  (w_tick)
    );

    assign w_song_end  = song_done || (seconds >= c_MAX_SEC);
    assign w_pause_inc = r_pause_cnt + c_PCNT_W'(1);

    // ------------------------------------------------------------------
    // Next-state and next-output logic. stop is tested first everywhere
    // so that it beats play/pause/end arriving in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx     = r_state;
        w_countdown_nx = r_countdown;
        w_pause_cnt_nx = r_pause_cnt;
        w_start_nx     = 1'b0;
        w_finished_nx  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_countdown_nx = '0;
                if (play && !stop) begin
                    w_state_nx     = S_COUNTIN;
                    w_countdown_nx = c_COUNT_IN;
                end
            end

            S_COUNTIN: begin
                if (stop) begin
                    w_state_nx     = S_IDLE;
                    w_countdown_nx = '0;
                end else if (w_tick) begin
                    if (r_countdown == c_CD_W'(1)) begin
                        w_state_nx     = S_PLAY;
                        w_start_nx     = 1'b1;
                        w_countdown_nx = '0;
                    end else begin
                        w_countdown_nx = r_countdown - c_CD_W'(1);
                    end
                end
            end

            S_PLAY: begin
                w_countdown_nx = '0;
                if (stop) begin
                    w_state_nx = S_IDLE;
                end else if (w_song_end) begin
                    w_state_nx    = S_DONE;
                    w_finished_nx = 1'b1;
                end else if (pause) begin
                    w_state_nx = S_PAUSED;
                end
            end

            S_PAUSED: begin
                w_countdown_nx = '0;
                if (stop) begin
                    w_state_nx = S_IDLE;
                end else if (pause) begin
                    // Resume without start_song so the timer keeps its value.
                    w_state_nx = S_PLAY;
                end else if (w_tick) begin
                    if (w_pause_inc >= c_PAUSE_TO) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_pause_cnt_nx = w_pause_inc;
                    end
                end
            end

            S_DONE: begin
                w_countdown_nx = '0;
                if (stop) begin
                    w_state_nx = S_IDLE;
                end else if (play) begin
                    w_state_nx     = S_COUNTIN;
                    w_countdown_nx = c_COUNT_IN;
                end
            end

            default: begin
                w_state_nx     = S_IDLE;
                w_countdown_nx = '0;
            end
        endcase

        // The pause counter only lives inside PAUSED, so it is zero on entry.
        if (w_state_nx != S_PAUSED) begin
            w_pause_cnt_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_countdown  <= '0;
            r_pause_cnt  <= '0;
            r_start      <= 1'b0;
            r_finished   <= 1'b0;
            r_pause_song <= 1'b1;
            r_playing    <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_countdown  <= w_countdown_nx;
            r_pause_cnt  <= w_pause_cnt_nx;
            r_start      <= w_start_nx;
            r_finished   <= w_finished_nx;
            r_pause_song <= (w_state_nx != S_PLAY);
            r_playing    <= (w_state_nx == S_PLAY);
        end
    end

    assign start_song = r_start;
    assign pause_song = r_pause_song;
    assign playing    = r_playing;
    assign finished   = r_finished;
    assign countdown  = r_countdown;
    assign state      = r_state;

endmodule : song_control
`default_nettype wire
